// File: rtl/sort_pkg.sv
// Shared types and default sizing for the sequential sorter.
package sort_pkg;
  localparam int W_DEFAULT = 4;
  localparam int N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_sort_if.sv
// Input/output vector handshake bundle for seq_sort_ctrl.
interface seq_sort_if
  import sort_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int N = N_DEFAULT
);
  logic [N*W-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic           busy;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy
  );
endinterface

// File: rtl/compare_swap.sv
// Unsigned compare-swap: larger value on hi, smaller on lo; ties keep a on hi.
module compare_swap #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  logic a_ge_b;

  assign a_ge_b = (a >= b);
  assign hi     = a_ge_b ? a : b;
  assign lo     = a_ge_b ? b : a;
endmodule

// File: rtl/seq_sort_ctrl.sv
// Sequential insertion-network sorter sharing one compare-swap unit.
//   state | meaning
//   IDLE  | ready for a new vector
//   SORT  | one compare-swap on (k, k-1) per cycle
//   DONE  | result presented until out_ready
module seq_sort_ctrl
  import sort_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int N = N_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_sort_if.slave  bus
);
  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t                state, state_nxt;
  logic [N-1:0][W-1:0]   line, line_nxt;
  logic [CW-1:0]         l, l_nxt;
  logic [CW-1:0]         k, k_nxt;
  logic [W-1:0]          cs_a, cs_b, cs_hi, cs_lo;
  logic                  accept;

  assign cs_a = line[k];
  assign cs_b = line[k - ONE];

  compare_swap #(.W(W)) u_cs (
    .a  (cs_a),
    .b  (cs_b),
    .hi (cs_hi),
    .lo (cs_lo)
  );

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = line;
  assign accept        = bus.in_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      line  <= '0;
      l     <= ONE;
      k     <= ONE;
    end else begin
      state <= state_nxt;
      line  <= line_nxt;
      l     <= l_nxt;
      k     <= k_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    line_nxt  = line;
    l_nxt     = l;
    k_nxt     = k;
    case (state)
      IDLE: begin
        if (accept) begin
          line_nxt  = bus.in_data;
          l_nxt     = ONE;
          k_nxt     = ONE;
          state_nxt = SORT;
        end
      end
      SORT: begin
        line_nxt[k]       = cs_hi;
        line_nxt[k - ONE] = cs_lo;
        // walk k down to 1, then widen the sorted prefix by one element
        if (k > ONE) begin
          k_nxt = k - ONE;
        end else if (l < LAST) begin
          l_nxt = l + ONE;
          k_nxt = l + ONE;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: doc/seq_sort_ctrl.md
SEQ_SORT_CTRL -- requirements
Module: seq_sort_ctrl

Interface
REQ-001 SHALL have parameter W, default 4: bit width of one element (line).
REQ-002 SHALL have parameter N, default 4: number of elements; N >= 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_data, input, N*W: element k at bits [W*k +: W].
REQ-006 SHALL have port in_valid, input, 1: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts in_data this cycle.
REQ-008 SHALL have port out_data, output, N*W: sorted vector, element k at [W*k +: W].
REQ-009 SHALL have port out_valid, output, 1: out_data holds a finished result.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts out_data this cycle.
REQ-011 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-012 SHALL sort unsigned elements ascending by index: element N-1 largest, element 0 smallest; equal values are kept unchanged.
REQ-013 SHALL use exactly one compare-swap unit, time-shared across all comparator steps.
REQ-014 SHALL apply the insertion-network schedule: for l = 1..N-1, for k = l down to 1, compare-swap pair (k, k-1), one pair per cycle.
REQ-015 Compare-swap SHALL place max(line[k], line[k-1]) in line[k] and min in line[k-1], unsigned W-bit compare, no width growth.
REQ-016 SHALL implement FSM states IDLE, SORT, DONE.
REQ-017 IDLE: in_ready = 1; when in_valid && in_ready, the block latches in_data into the line registers, loads l = 1, k = 1, and moves to SORT.
REQ-018 SORT: one compare-swap per cycle on (k, k-1).
REQ-019 SORT counter update: if k > 1 then k--; else if l < N-1 then l++ and k = l+1; else move to DONE.
REQ-020 SORT SHALL last exactly N(N-1)/2 cycles (6 for N = 4); in_valid and in_data are ignored during SORT.
REQ-021 DONE: out_valid = 1 and out_data = line registers, held stable while out_ready is low.
REQ-022 DONE with out_ready = 1 SHALL move to IDLE next cycle; there is no same-cycle accept of new input.
REQ-023 Latency SHALL be N(N-1)/2 + 1 cycles from the accept edge to out_valid high; best throughput is one vector per N(N-1)/2 + 2 cycles.
REQ-024 in_ready SHALL be high only in IDLE; out_valid SHALL be high only in DONE; both are registered-state decodes with no combinational path from in_valid or out_ready.
REQ-025 Already-sorted and all-equal inputs SHALL take the same cycle count as any other input (data-independent timing).

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, l = 1, k = 1, and line registers all zero, independent of clk.
REQ-027 Output values under reset: in_ready = 1, out_valid = 0, busy = 0, out_data = 0.
REQ-028 Reset asserted mid-SORT or in DONE SHALL discard the in-progress vector; no out_valid follows.
REQ-029 After rst_n deasserts, the first accept SHALL occur no earlier than the first rising clk edge.

Structure
REQ-030 Shared package sort_pkg SHALL hold the state enum (IDLE/SORT/DONE) and the default constants W = 4 and N = 4.
REQ-031 Compare-swap SHALL be a sub-module compare_swap (parameter W; inputs a, b; outputs hi, lo), instantiated once.
REQ-032 Counters l and k SHALL be $clog2(N) bits wide.

Verification
REQ-033 in_data = 16'h1234 accepted -> out_valid exactly 7 cycles later, out_data = 16'h4321.
REQ-034 in_data = 16'h4321 (already sorted) -> out_data = 16'h4321, same 7-cycle latency.
REQ-035 in_data = 16'h5A5A (duplicates) -> out_data = 16'hAA55; in_data = 16'h0F0F -> 16'hFF00.
REQ-036 Hold out_ready = 0 for 5 cycles in DONE while driving in_valid = 1 -> out_data stable, in_ready = 0, nothing new accepted; release -> IDLE next cycle.
REQ-037 Pulse rst_n low in the 3rd SORT cycle of 16'h1234 -> outputs reach reset values asynchronously, no out_valid; next input 16'h0312 -> 16'h3210.
REQ-038 Back-to-back vectors with out_ready tied high -> accepts spaced exactly 8 cycles apart, every result correct.
